// File: rtl/fx68k_clken.sv
// rtl/fx68k_clken.sv - phase-enable and reset sequencer feeding the fx68k core
// Optional freeze input enabled by defining FX68K_CLKEN_HOLD_EN.

package fx68k_pkg;
    typedef struct packed {
        logic coreReset;
        logic pwrUp;
        logic enPhi1;
        logic enPhi2;
    } s_clks;
endpackage

module fx68k_clken #(
    parameter int DIV      = 2,
    parameter int RST_HOLD = 16
) (
    input  logic              clk,
    input  logic              extReset,
    input  logic              coldStart,
`ifdef FX68K_CLKEN_HOLD_EN
    input  logic              hold,
`endif
    output logic              enPhi1,
    output logic              enPhi2,
    output logic              coreReset,
    output logic              pwrUp,
    output fx68k_pkg::s_clks  clks
);

    localparam logic [3:0] DIV_LAST  = 4'(DIV - 1);
    localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

    typedef enum logic [1:0] {
        RESET,
        STRETCH,
        RUN
    } rstState_t;

    rstState_t   state;
    rstState_t   stateNxt;
    logic [3:0]  divCnt;
    logic [3:0]  divCntNxt;
    logic        ph;
    logic        phNxt;
    logic [7:0]  holdCnt;
    logic [7:0]  holdCntNxt;
    logic        enPhi1Nxt;
    logic        enPhi2Nxt;
    logic        coreResetNxt;
    logic        pwrUpNxt;
    logic        freeze;

`ifdef FX68K_CLKEN_HOLD_EN
    assign freeze = hold;
`else
    assign freeze = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (extReset) begin
            state     <= RESET;
            divCnt    <= 4'd0;
            ph        <= 1'b0;
            holdCnt   <= HOLD_INIT;
            enPhi1    <= 1'b0;
            enPhi2    <= 1'b0;
            coreReset <= 1'b1;
            pwrUp     <= coldStart;
        end else begin
            state     <= stateNxt;
            divCnt    <= divCntNxt;
            ph        <= phNxt;
            holdCnt   <= holdCntNxt;
            enPhi1    <= enPhi1Nxt;
            enPhi2    <= enPhi2Nxt;
            coreReset <= coreResetNxt;
            pwrUp     <= pwrUpNxt;
        end
    end

    // Divider: ph records which phase fires next, so strobes strictly alternate.
    always_comb begin
        divCntNxt = divCnt;
        phNxt     = ph;
        enPhi1Nxt = 1'b0;
        enPhi2Nxt = 1'b0;
        if (!freeze) begin
            if (divCnt == DIV_LAST) begin
                divCntNxt = 4'd0;
                phNxt     = ~ph;
                enPhi1Nxt = ~ph;
                enPhi2Nxt = ph;
            end else begin
                divCntNxt = divCnt + 4'd1;
            end
        end
    end

    // Stretch counts completed PHI2 strobes; a frozen strobe does not count.
    always_comb begin
        stateNxt     = state;
        holdCntNxt   = holdCnt;
        coreResetNxt = coreReset;
        pwrUpNxt     = pwrUp;
        case (state)
            RESET, STRETCH: begin
                stateNxt = STRETCH;
                if (enPhi2 && !freeze && (holdCnt != 8'd0)) begin
                    if (holdCnt == 8'd1) begin
                        holdCntNxt   = 8'd0;
                        coreResetNxt = 1'b0;
                        pwrUpNxt     = 1'b0;
                        stateNxt     = RUN;
                    end else begin
                        holdCntNxt = holdCnt - 8'd1;
                    end
                end
            end
            RUN: begin
                holdCntNxt   = 8'd0;
                coreResetNxt = 1'b0;
                pwrUpNxt     = 1'b0;
            end
            default: begin
                stateNxt = RESET;
            end
        endcase
    end

    assign clks.coreReset = coreReset;
    assign clks.pwrUp     = pwrUp;
    assign clks.enPhi1    = enPhi1;
    assign clks.enPhi2    = enPhi2;

    aEnablesExclusive: assert property (@(posedge clk) !(enPhi1 && enPhi2));
    aDivInRange:       assert property (@(posedge clk) disable iff (extReset) divCnt <= DIV_LAST);

endmodule

// File: tb/tb_fx68k_clken.sv
// tb/tb_fx68k_clken.sv - directed and random checks of fx68k_clken at DIV=2/1/4
// Hold scenario compiled only with FX68K_CLKEN_HOLD_EN.

module tb_fx68k_clken;
    import fx68k_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic extReset;
    logic coldStart;
    logic hold;

    logic  e1 [3];
    logic  e2 [3];
    logic  cr [3];
    logic  pu [3];
    s_clks c  [3];
    logic [3:0] o  [3];
    logic [3:0] pr [3];

    int vectors     = 0;
    int miscompares = 0;
    int divs [3]    = '{2, 1, 4};
    int holds [3]   = '{3, 3, 2};
    int nxt [3];
    int gap [3];
    bit gapValid [3];
    logic prevExt;
    logic prevCold;

    fx68k_clken #(.DIV(2), .RST_HOLD(3)) u0 (
        .clk(clk), .extReset(extReset), .coldStart(coldStart),
`ifdef FX68K_CLKEN_HOLD_EN
        .hold(1'b0),
`endif
        .enPhi1(e1[0]), .enPhi2(e2[0]), .coreReset(cr[0]), .pwrUp(pu[0]), .clks(c[0]));

    fx68k_clken #(.DIV(1), .RST_HOLD(3)) u1 (
        .clk(clk), .extReset(extReset), .coldStart(coldStart),
`ifdef FX68K_CLKEN_HOLD_EN
        .hold(1'b0),
`endif
        .enPhi1(e1[1]), .enPhi2(e2[1]), .coreReset(cr[1]), .pwrUp(pu[1]), .clks(c[1]));

    fx68k_clken #(.DIV(4), .RST_HOLD(2)) u2 (
        .clk(clk), .extReset(extReset), .coldStart(coldStart),
`ifdef FX68K_CLKEN_HOLD_EN
        .hold(hold),
`endif
        .enPhi1(e1[2]), .enPhi2(e2[2]), .coreReset(cr[2]), .pwrUp(pu[2]), .clks(c[2]));

    always_comb begin
        for (int d = 0; d < 3; d++) o[d] = {cr[d], pu[d], e1[d], e2[d]};
    end

    task automatic chk(input string tag, input int d, input logic [3:0] obs, input logic [3:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s u%0d observed=%b expected=%b", tag, d, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {coreReset,pwrUp,enPhi1,enPhi2} after edge e counted from reset release.
    function automatic logic [3:0] expAt(input int e, input int div, input int rh, input logic cold);
        logic inRst;
        inRst = (e < 2 * rh * div);
        return {inRst, cold & inRst, (e % (2 * div)) == div - 1, (e % (2 * div)) == 2 * div - 1};
    endfunction

    task automatic checkAll(input string tag, input int e, input logic cold);
        for (int d = 0; d < 3; d++) begin
            chk(tag, d, o[d], expAt(e, divs[d], holds[d], cold));
            chk({tag, "_clks"}, d, c[d], o[d]);
        end
    endtask

    task automatic checkReset(input string tag, input logic cold);
        for (int d = 0; d < 3; d++) begin
            chk(tag, d, o[d], {1'b1, cold, 2'b00});
            chk({tag, "_clks"}, d, c[d], o[d]);
        end
    endtask

    task automatic runPhase(input string tag, input int n, input logic cold);
        for (int e = 0; e < n; e++) begin
            step();
            checkAll(tag, e, cold);
        end
    endtask

    initial begin
        extReset  = 1'b1;
        coldStart = 1'b1;
        hold      = 1'b0;

        // Cold reset and base timing
        for (int k = 0; k < 5; k++) begin
            step();
            checkReset("coldRst", 1'b1);
        end
        extReset = 1'b0;
        runPhase("coldRun", 18, 1'b1);

        // Warm reset
        extReset  = 1'b1;
        coldStart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checkReset("warmRst", 1'b0);
        end
        extReset = 1'b0;
        runPhase("warmRun", 18, 1'b0);

        // Reset pulse after the second stretch strobe of u0
        extReset  = 1'b1;
        coldStart = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checkReset("midRst0", 1'b1);
        end
        extReset = 1'b0;
        runPhase("midPre", 8, 1'b1);
        extReset = 1'b1;
        step();
        checkReset("midRst1", 1'b1);
        extReset = 1'b0;
        runPhase("midPost", 18, 1'b1);

`ifdef FX68K_CLKEN_HOLD_EN
        // u2 frozen for edges 2..8 while its divCnt is 2
        extReset = 1'b1;
        step();
        checkReset("holdRst", 1'b1);
        extReset = 1'b0;
        for (int e = 0; e < 26; e++) begin
            logic [3:0] ex2;
            int f;
            step();
            for (int d = 0; d < 2; d++) begin
                chk("holdRef", d, o[d], expAt(e, divs[d], holds[d], 1'b1));
            end
            f = e - 7;
            ex2 = {e < 23, e < 23, 2'b00};
            if (e >= 9) begin
                ex2[1] = ((f % 8) == 3);
                ex2[0] = ((f % 8) == 7);
            end
            chk("holdRun", 2, o[2], ex2);
            chk("holdRun_clks", 2, c[2], o[2]);
            if (e == 1) hold = 1'b1;
            if (e == 8) hold = 1'b0;
        end
`endif

        // Random traffic: struct consistency, alternation, reset behaviour
        for (int d = 0; d < 3; d++) begin
            nxt[d]      = 1;
            gap[d]      = 0;
            gapValid[d] = 1'b0;
        end
        for (int i = 0; i < 10000; i++) begin
            extReset  = (i == 0) || ($urandom_range(0, 63) == 0);
            coldStart = 1'($urandom_range(0, 1));
            hold      = ($urandom_range(0, 7) == 0);
            prevExt   = extReset;
            prevCold  = coldStart;
            for (int d = 0; d < 3; d++) pr[d] = o[d];
            step();
            for (int d = 0; d < 3; d++) begin
                chk("rndClks", d, c[d], o[d]);
                if (prevExt) begin
                    chk("rndRst", d, o[d], {1'b1, prevCold, 2'b00});
                    nxt[d]      = 1;
                    gap[d]      = 0;
                    gapValid[d] = 1'b0;
                end else begin
                    chk("rndNoRise", d, {2'b00, o[d][3] & ~pr[d][3], o[d][2] & ~pr[d][2]}, 4'b0000);
                    gap[d]++;
                    if (o[d][1] || o[d][0]) begin
                        chk("rndOrder", d, {2'b00, o[d][1], o[d][0]}, (nxt[d] == 1) ? 4'b0010 : 4'b0001);
                        nxt[d] = o[d][1] ? 2 : 1;
                        if (d < 2 && gapValid[d]) chk("rndGap", d, 4'(gap[d]), 4'(divs[d]));
                        gap[d]      = 0;
                        gapValid[d] = 1'b1;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
